nvram_upload_reader: RTL

- Serves HPS save/upload requests (OSD "save hiscore/NVRAM"); it is the read-side counterpart of the ioctl ROM download path.
- During an upload with a matching index, it pauses the core CPU, then streams bytes from a core-side dual-port RAM onto ioctl_din, one byte per HPS read strobe.
- Keeps a running byte count and an 8-bit additive checksum for OSD and debug.
- Sits in the emu top level, between hps_io and the game's work RAM second port.

---
 rtl/nvram_upload_reader_pkg.sv | 24 ++
 rtl/nvram_upload_reader_edge_detect_rise.sv | 23 ++
 rtl/nvram_upload_reader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/nvram_upload_reader_pkg.sv
// Shared definitions for the NVRAM / hiscore upload reader.
// FSM state codes are plain localparams so older code that compares raw
// 3-bit values keeps working.
package nvram_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PAUSE = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  // Byte returned to the HPS for any address outside the valid window.
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  // ioctl_index the OSD uses for "save NVRAM/hiscore".
  localparam logic [7:0] DEFAULT_UPLOAD_INDEX = 8'd4;

  // Running 8-bit additive checksum; wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
    return sum + data;
  endfunction

endpackage

// File: rtl/nvram_upload_reader_edge_detect_rise.sv
// Registered rising-edge detector: remembers the previous level of sig and
// flags the first cycle on which sig is seen high.
module edge_detect_rise (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic sig,
  output logic rise
);

  logic prev_r;

  // Capture last cycle's level of the input
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= sig;
    end
  end

  assign rise = sig & ~prev_r;

endmodule

// File: rtl/nvram_upload_reader.sv
// Read side of the HPS ioctl path: on an upload with our index, halt the core
// CPU, then serve bytes from the work RAM second port one per HPS read strobe,
// prefetching the byte after the one just consumed. Keeps a byte count and an
// additive checksum for the OSD.
module nvram_upload_reader
  import nvram_pkg::*;
#(
  parameter logic [7:0]  UPLOAD_INDEX  = DEFAULT_UPLOAD_INDEX,
  parameter int          AW            = 10,
  parameter int          SIZE          = 1024,
  parameter int          RAM_LAT       = 1,
  parameter logic [15:0] PAUSE_TIMEOUT = 16'd4096
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   byte_count,
  output logic [7:0]    checksum
);

  localparam logic [25:0] SIZE_W     = 26'(SIZE);
  localparam logic [1:0]  LAT_LAST   = 2'(RAM_LAT - 1);
  localparam logic [15:0] TIMER_LAST = PAUSE_TIMEOUT - 16'd1;
  localparam logic [AW:0] COUNT_MAX  = {(AW+1){1'b1}};
  localparam logic [AW:0] COUNT_ONE  = {{AW{1'b0}}, 1'b1};

  // Registered state and outputs
  logic [2:0]    state_r;
  logic [15:0]   timer_r;
  logic [1:0]    lat_cnt_r;
  logic [AW-1:0] tgt_addr_r;
  logic          tgt_ok_r;
  logic [7:0]    din_r;
  logic [AW-1:0] ram_addr_r;
  logic          ram_rd_r;
  logic          busy_r;
  logic          done_r;
  logic          pause_req_r;
  logic [AW:0]   byte_count_r;
  logic [7:0]    checksum_r;

  // Next-state values
  logic [2:0]    state_nxt_s;
  logic [15:0]   timer_nxt_s;
  logic [1:0]    lat_nxt_s;
  logic [AW-1:0] tgt_addr_nxt_s;
  logic          tgt_ok_nxt_s;
  logic [7:0]    din_nxt_s;
  logic [AW:0]   count_nxt_s;
  logic [7:0]    csum_nxt_s;
  logic          fetch_nxt_s;

  logic          active_s;
  logic          start_s;
  logic          rd_rise_s;
  logic [25:0]   next_tgt_s;

  assign active_s   = ioctl_upload & (ioctl_index == UPLOAD_INDEX);
  // One past the address just read; computed wide so high address bits
  // compare as out of range instead of aliasing into the RAM.
  assign next_tgt_s = {1'b0, ioctl_addr} + 26'd1;

  edge_detect_rise u_active_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .sig     (active_s),
    .rise    (start_s)
  );

  edge_detect_rise u_rd_edge (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .sig     (ioctl_rd),
    .rise    (rd_rise_s)
  );

  // Next-state logic: upload sequencing, prefetch control, count/checksum
  always_comb begin
    state_nxt_s    = state_r;
    timer_nxt_s    = timer_r;
    lat_nxt_s      = lat_cnt_r;
    tgt_addr_nxt_s = tgt_addr_r;
    tgt_ok_nxt_s   = tgt_ok_r;
    din_nxt_s      = din_r;
    count_nxt_s    = byte_count_r;
    csum_nxt_s     = checksum_r;

    // Any strobe during an upload consumes whatever is on ioctl_din, even if
    // it arrives early (protocol violation tolerated, not trapped).
    if (rd_rise_s && (state_r != ST_IDLE)) begin
      csum_nxt_s = csum_add(checksum_r, din_r);
      if (byte_count_r != COUNT_MAX) begin
        count_nxt_s = byte_count_r + COUNT_ONE;
      end else begin
        count_nxt_s = byte_count_r;
      end
    end else begin
      csum_nxt_s = checksum_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s    = ST_PAUSE;
          count_nxt_s    = '0;
          csum_nxt_s     = 8'd0;
          tgt_addr_nxt_s = '0;
          tgt_ok_nxt_s   = (SIZE_W != 26'd0);
          timer_nxt_s    = 16'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PAUSE: begin
        if (!active_s) begin
          state_nxt_s = ST_DONE;
        end else if (pause_ack || (timer_r == TIMER_LAST)) begin
          state_nxt_s = ST_FETCH;
        end else begin
          timer_nxt_s = timer_r + 16'd1;
        end
      end
      ST_FETCH: begin
        if (!active_s) begin
          state_nxt_s = ST_DONE;
        end else if (tgt_ok_r) begin
          lat_nxt_s   = 2'd0;
          state_nxt_s = ST_WAIT;
        end else begin
          din_nxt_s   = FILL_BYTE;
          state_nxt_s = ST_READY;
        end
      end
      ST_WAIT: begin
        if (!active_s) begin
          state_nxt_s = ST_DONE;
        end else if (lat_cnt_r == LAT_LAST) begin
          din_nxt_s   = ram_q;
          state_nxt_s = ST_READY;
        end else begin
          lat_nxt_s = lat_cnt_r + 2'd1;
        end
      end
      ST_READY: begin
        if (!active_s) begin
          state_nxt_s = ST_DONE;
        end else if (rd_rise_s) begin
          tgt_addr_nxt_s = next_tgt_s[AW-1:0];
          tgt_ok_nxt_s   = (next_tgt_s < SIZE_W);
          state_nxt_s    = ST_FETCH;
        end else begin
          state_nxt_s = ST_READY;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    // RAM read is issued on entry to FETCH so ram_rd/ram_addr are valid
    // during the FETCH cycle itself.
    fetch_nxt_s = (state_nxt_s == ST_FETCH) & tgt_ok_nxt_s;
  end

  // State and output registers
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      timer_r      <= 16'd0;
      lat_cnt_r    <= 2'd0;
      tgt_addr_r   <= '0;
      tgt_ok_r     <= 1'b0;
      din_r        <= FILL_BYTE;
      ram_addr_r   <= '0;
      ram_rd_r     <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pause_req_r  <= 1'b0;
      byte_count_r <= '0;
      checksum_r   <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      timer_r      <= timer_nxt_s;
      lat_cnt_r    <= lat_nxt_s;
      tgt_addr_r   <= tgt_addr_nxt_s;
      tgt_ok_r     <= tgt_ok_nxt_s;
      din_r        <= din_nxt_s;
      ram_addr_r   <= fetch_nxt_s ? tgt_addr_nxt_s : ram_addr_r;
      ram_rd_r     <= fetch_nxt_s;
      busy_r       <= (state_nxt_s != ST_IDLE);
      done_r       <= (state_nxt_s == ST_DONE);
      pause_req_r  <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      byte_count_r <= count_nxt_s;
      checksum_r   <= csum_nxt_s;
    end
  end

  assign ioctl_din  = din_r;
  assign pause_req  = pause_req_r;
  assign ram_addr   = ram_addr_r;
  assign ram_rd     = ram_rd_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign byte_count = byte_count_r;
  assign checksum   = checksum_r;

endmodule
